// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour command sequencer:
// FSM state encoding, command opcodes, headings and response bytes.
package tour_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VERT   = 3'd1,
    S_WAIT_V = 3'd2,
    S_HORZ   = 3'd3,
    S_WAIT_H = 3'd4
  } tour_state_e;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;

  // Pack a cmd_proc command word: {opcode, heading, squares}.
  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] head,
                                         input logic [3:0] sq);
    return {op, head, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command/response bus between UART_wrapper, the tour sequencer and cmd_proc.
//   cmd_UART/cmd_rdy_UART/clr_cmd_rdy_UART : UART_wrapper side
//   cmd/cmd_rdy/clr_cmd_rdy/send_resp/resp : cmd_proc side
// slave modport = sequencer view, master modport = environment view.
interface tour_cmd_seq_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport slave (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport master (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_move_dec.sv
// Decode a one-hot knight move into a vertical (opcode 2) and a horizontal
// (opcode 3, fanfare) cmd_proc command. Lowest set bit wins; move = 0 decodes
// as bit 0. mv_ok flags a move that is exactly one-hot.
//   move     in  8   one-hot move from solver memory
//   vert_cmd out 16  vertical command
//   horz_cmd out 16  horizontal command
//   mv_ok    out 1   move is exactly one-hot
module tour_move_dec
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd,
  output logic        mv_ok
);

  logic [2:0] idx;
  logic [7:0] v_head, h_head;
  logic [3:0] v_sq, h_sq;

  // Lowest set bit; loop runs high-to-low so the lowest hit is written last.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (move[i]) idx = 3'(i);
    end
  end

  // Bit -> (heading, |dy|) and (heading, |dx|).
  always_comb begin
    v_head = HEAD_N; v_sq = 4'd2;
    h_head = HEAD_E; h_sq = 4'd1;
    case (idx)
      3'd0: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
      3'd1: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
      3'd2: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
      3'd3: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
      3'd4: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
      3'd5: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
      3'd6: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
      default: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
    endcase
  end

  assign vert_cmd = mk_cmd(OP_MOVE, v_head, v_sq);
  assign horz_cmd = mk_cmd(OP_FANFARE, h_head, h_sq);
  assign mv_ok    = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);

endmodule

// File: rtl/tour_cmd_seq.sv
// Command source for cmd_proc during a knight's tour. In IDLE, UART commands
// pass straight through; after tour_go it walks the move list issuing a
// vertical then a horizontal command per move, paced by send_resp.
//   clk, rst_n  clock, async active-low reset
//   tour_go     start pulse (ignored outside IDLE)
//   move        one-hot move at mv_indx (async solver memory read)
//   mv_indx     current move index
//   bus         command/response interface (slave modport)
// Optional macro TOUR_MV_CHECK_EN: abort the tour to IDLE when move is not
// exactly one-hot in VERT. Default: lowest set bit is decoded.
module tour_cmd_seq
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tour_go,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  tour_cmd_seq_if.slave bus
);

  localparam int unsigned IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  localparam logic [2:0] IDLE   = S_IDLE;
  localparam logic [2:0] VERT   = S_VERT;
  localparam logic [2:0] WAIT_V = S_WAIT_V;
  localparam logic [2:0] HORZ   = S_HORZ;
  localparam logic [2:0] WAIT_H = S_WAIT_H;

`ifdef TOUR_MV_CHECK_EN
  localparam bit MV_CHECK = 1'b1;
`else
  localparam bit MV_CHECK = 1'b0;
`endif

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic [15:0]      vert_cmd, horz_cmd;
  logic             mv_ok;
  logic             mv_abort;
  logic             last_mv;

  tour_move_dec u_dec (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .mv_ok    (mv_ok)
  );

  assign mv_abort = MV_CHECK && !mv_ok;
  assign last_mv  = (mv_indx_q == LAST_IDX);
  assign mv_indx  = mv_indx_q;

  // State, index and tour-mode cmd_rdy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Next state and outputs; clr_cmd_rdy takes priority over send_resp because
  // send_resp is simply not looked at in VERT/HORZ.
  always_comb begin
    state_d              = state_q;
    mv_indx_d            = mv_indx_q;
    cmd_rdy_d            = 1'b0;
    bus.cmd              = vert_cmd;
    bus.cmd_rdy          = cmd_rdy_q;
    bus.clr_cmd_rdy_UART = 1'b0;
    bus.resp             = RESP_ACK;
    case (state_q)
      IDLE: begin
        bus.cmd              = bus.cmd_UART;
        bus.cmd_rdy          = bus.cmd_rdy_UART;
        bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
        bus.resp             = RESP_DONE;
        if (tour_go) begin
          mv_indx_d = '0;
          state_d   = VERT;
        end
      end
      VERT: begin
        if (mv_abort)             state_d   = IDLE;
        else if (bus.clr_cmd_rdy) state_d   = WAIT_V;
        else                      cmd_rdy_d = 1'b1;
      end
      WAIT_V: begin
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        bus.cmd = horz_cmd;
        if (bus.clr_cmd_rdy) state_d   = WAIT_H;
        else                 cmd_rdy_d = 1'b1;
      end
      WAIT_H: begin
        bus.cmd  = horz_cmd;
        bus.resp = last_mv ? RESP_DONE : RESP_ACK;
        if (bus.send_resp) begin
          if (last_mv) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + IDX_W'(1);
            state_d   = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Command source for `cmd_proc` during a knight's tour. When not touring it passes UART commands straight through. After `tour_go` it walks the solved move list and, for each knight move, issues two commands on the `cmd`/`cmd_rdy`/`clr_cmd_rdy` interface: a vertical move, then a horizontal move with fanfare. It paces itself on `cmd_proc`'s `send_resp`, and it sits between `UART_wrapper`, the tour solver memory and `cmd_proc`.

## Interface
- `NUM_MOVES`, default 24: number of moves in a tour; the move index runs 0..NUM_MOVES-1.
- `clk`  in  1  system clock; the block has one clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `tour_go`  in  1  one-cycle pulse that starts a tour.
- `move`  in  8  one-hot move at `mv_indx`, read asynchronously from the solver memory.
- `mv_indx`  out  5  current move index.
- `cmd_UART`  in  16  command from `UART_wrapper`.
- `cmd_rdy_UART`  in  1  UART command valid.
- `clr_cmd_rdy_UART`  out  1  consume strobe to `UART_wrapper`.
- `cmd`  out  16  command to `cmd_proc`.
- `cmd_rdy`  out  1  command valid to `cmd_proc`.
- `clr_cmd_rdy`  in  1  `cmd_proc` has consumed the command.
- `send_resp`  in  1  `cmd_proc` has finished the command.
- `resp`  out  8  response byte to `UART_wrapper`.

## Operation
- Command format:
  - `[15:12]` opcode: 4'h2 = move, 4'h3 = move with fanfare.
  - `[11:4]` heading: N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
  - `[3:0]` number of squares.
- Move bits as (dx, dy): 0 = (+1,+2), 1 = (-1,+2), 2 = (-2,+1), 3 = (-2,-1), 4 = (-1,-2), 5 = (+1,-2), 6 = (+2,-1), 7 = (+2,+1).
- Vertical command: opcode 4'h2; heading N if dy > 0, else S; squares = |dy|.
- Horizontal command: opcode 4'h3; heading E if dx > 0, else W; squares = |dx|.
- FSM states: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: pass-through. `cmd = cmd_UART`, `cmd_rdy = cmd_rdy_UART`, `clr_cmd_rdy_UART = clr_cmd_rdy`. On `tour_go`: `mv_indx` <= 0, go to VERT.
  - VERT: `cmd` = vertical command. On `clr_cmd_rdy`, go to WAIT_V.
  - WAIT_V: on `send_resp`, go to HORZ.
  - HORZ: `cmd` = horizontal command. On `clr_cmd_rdy`, go to WAIT_H.
  - WAIT_H: on `send_resp`:
    - if `mv_indx == NUM_MOVES-1`, go to IDLE;
    - otherwise `mv_indx` increments and the FSM goes to VERT.
- Outside IDLE:
  - `cmd_rdy_UART` is ignored and `clr_cmd_rdy_UART` = 0.
  - `tour_go` is ignored.
  - `send_resp` has no effect in VERT or HORZ.
- `resp`:
  - 8'h5A in VERT, WAIT_V and HORZ, and in WAIT_H when the move is not the last;
  - 8'hA5 in IDLE and in WAIT_H of the last move.
- `mv_indx` holds its value in IDLE after a tour ends; the next `tour_go` clears it.

## Timing
- Reset values: `cmd_rdy` = 0, `mv_indx` = 0, `clr_cmd_rdy_UART` = 0, `resp` = 8'hA5, state = IDLE.
- Pass-through in IDLE is combinational: zero latency.
- Tour-mode `cmd_rdy` is registered:
  - it goes high the cycle after the state becomes VERT or HORZ;
  - it goes low the cycle after `clr_cmd_rdy`.
- Tour-mode `cmd` is combinational from `move` and the current state.
- `move` must be valid within one cycle of `mv_indx` changing.
- Latency from `tour_go` to the first `cmd_rdy`: 2 cycles.
- If `clr_cmd_rdy` and `send_resp` are both high in the same cycle in VERT or HORZ, `clr_cmd_rdy` wins and `send_resp` is lost.
- Reset asserted in any state returns all outputs to reset values immediately; no command is left pending.

## Configuration
- Macro `TOUR_MV_CHECK_EN`.
- Defined:
  - in VERT, if `move` is not exactly one-hot, the tour aborts to IDLE with `cmd_rdy` = 0;
  - this includes `move` = 0.
- Undefined:
  - the lowest set bit of `move` is decoded;
  - `move` = 0 is treated as bit 0.

## Structure
- Package `tour_pkg` holds:
  - the state enum;
  - opcode constants 4'h2 and 4'h3;
  - the four heading constants;
  - `RESP_DONE` = 8'hA5 and `RESP_ACK` = 8'h5A.
- Sub-module `tour_move_dec`: combinational; maps the 8-bit `move` to `vert_cmd[15:0]`, `horz_cmd[15:0]` and `mv_ok`.

## Test plan
- Reset check: after reset `cmd_rdy` = 0, `mv_indx` = 0 and `resp` = 8'hA5. Then drive `cmd_UART` = 16'h2001 with `cmd_rdy_UART` = 1 → `cmd` = 16'h2001 and `cmd_rdy` = 1 in the same cycle, and `clr_cmd_rdy` appears on `clr_cmd_rdy_UART`.
- `tour_go` with `move` = 8'h01:
  - `cmd_rdy` rises 2 cycles later with `cmd` = 16'h2002;
  - after `clr_cmd_rdy` then `send_resp`, `cmd` = 16'h3BF1;
  - `resp` = 8'h5A throughout.
- `move` = 8'h08 → vertical command 16'h27F1, then horizontal command 16'h33F2.
- Full tour, with a `cmd_proc` model returning `send_resp` 20 cycles after each `clr_cmd_rdy`:
  - exactly 48 commands are issued and `mv_indx` reaches 23;
  - `resp` = 8'hA5 in the final WAIT_H;
  - the FSM returns to IDLE;
  - `tour_go` mid-tour is ignored.
- `move` = 8'h03:
  - with `TOUR_MV_CHECK_EN`: abort to IDLE, `cmd_rdy` never rises;
  - without it: vertical command 16'h2002.
- Assert `rst_n` low in WAIT_H at `mv_indx` = 7 → outputs return to reset values immediately; the next `tour_go` restarts from `mv_indx` = 0.
